// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, data width and default timing constants.
// Used by both the transmitter and receiver sides.
package uart_pkg;

  localparam int DATA_W      = 8;
  localparam int DEF_CLK_DIV = 16;
  localparam int DEF_DEPTH   = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_transmitter_fifo.sv
// Byte FIFO feeding the UART transmitter. Push/pop qualification is done by the caller;
// a push and a pop in the same cycle leave the occupancy unchanged.
module tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: FIFO-buffered bytes sent as start, 8 data bits LSB-first,
// optional even parity and one stop bit, each held for CLK_DIV clocks.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int DEPTH     = DEF_DEPTH,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clr_err,
  output logic              tx,
  output logic              busy,
  output logic              full,
  output logic              empty,
  output logic              overrun_err
);

  localparam int          CW       = $clog2(CLK_DIV);
  localparam logic [CW-1:0] TICK_VAL = CW'(CLK_DIV - 1);

  uart_state_e           state;
  uart_state_e           state_nxt;
  logic                  tx_nxt;
  logic [CW-1:0]         baud_cnt;
  logic [2:0]            bit_idx;
  logic [DATA_W-1:0]     shreg;
  logic                  par_bit;
  logic [DATA_W-1:0]     fifo_dout;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                  fifo_empty;
  logic                  pop;
  logic                  push;
  logic                  bit_tick;

  assign bit_tick = (baud_cnt == TICK_VAL);
  assign pop      = (state == IDLE) && !fifo_empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign push     = wr_en && (!full || pop);
  assign busy     = (state != IDLE);
  assign empty    = (fifo_count == '0);

  tx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (data_in),
    .dout  (fifo_dout),
    .full  (full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tx_nxt    = 1'b1;
    unique case (state)
      IDLE:   if (pop) state_nxt = START;
      START: begin
        tx_nxt = 1'b0;
        if (bit_tick) state_nxt = DATA;
      end
      DATA: begin
        tx_nxt = shreg[0];
        if (bit_tick && bit_idx == 3'd7) state_nxt = PARITY_EN ? PARITY : STOP;
      end
      PARITY: begin
        tx_nxt = par_bit;
        if (bit_tick) state_nxt = STOP;
      end
      STOP:   if (bit_tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // tx is registered from the current state, so the line lags the FSM by one clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx          <= 1'b1;
      baud_cnt    <= '0;
      bit_idx     <= '0;
      overrun_err <= 1'b0;
    end else begin
      tx <= tx_nxt;
      if (state == IDLE || bit_tick) baud_cnt <= '0;
      else                           baud_cnt <= baud_cnt + 1'b1;
      if (state == IDLE)                bit_idx <= '0;
      else if (state == DATA && bit_tick) bit_idx <= bit_idx + 1'b1;
      if (wr_en && full && !pop) overrun_err <= 1'b1;
      else if (clr_err)          overrun_err <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      shreg   <= fifo_dout;
      par_bit <= even_parity(fifo_dout);
    end else if (state == DATA && bit_tick) begin
      shreg <= shreg >> 1;
    end
  end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 Parameter CLK_DIV, default 16: clk cycles per serial bit; legal range 2..65535.
REQ-002 Parameter DEPTH, default 4: transmit FIFO depth in bytes; legal values are powers of two, 2..16.
REQ-003 Parameter PARITY_EN, default 1: 1 inserts an even-parity bit after the data bits; 0 gives 8N1 framing.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port wr_en, input, 1 bit: request to push data_in into the FIFO this cycle.
REQ-007 Port data_in, input, 8 bits: byte to transmit.
REQ-008 Port clr_err, input, 1 bit: synchronous clear of overrun_err.
REQ-009 Port tx, output, 1 bit: serial line; idles high.
REQ-010 Port busy, output, 1 bit: high while a frame is on the line (any state other than IDLE).
REQ-011 Port full, output, 1 bit: FIFO holds DEPTH entries.
REQ-012 Port empty, output, 1 bit: FIFO holds 0 entries.
REQ-013 Port overrun_err, output, 1 bit: sticky flag set when a write is dropped.

Function
REQ-014 The FIFO SHALL accept a write when wr_en=1 and either full=0 or a pop occurs in the same cycle; a simultaneous push and pop leaves the count unchanged.
REQ-015 A write with wr_en=1 and full=1 and no same-cycle pop SHALL be dropped, leave the FIFO unchanged, and set overrun_err on the next edge.
REQ-016 overrun_err SHALL stay high until clr_err=1; if clr_err and a dropped write coincide, set wins.
REQ-017 The FSM states SHALL be IDLE, START, DATA, PARITY and STOP.
REQ-018 IDLE with empty=0: pop the head byte into the shift register, compute even parity (XOR of the 8 bits), clear the baud counter, and go to START.
REQ-019 The baud counter SHALL run 0..CLK_DIV-1 outside IDLE; bit_tick is asserted when count equals CLK_DIV-1, after which the counter wraps to 0.
REQ-020 Each state SHALL hold tx for exactly CLK_DIV cycles: START drives 0, DATA drives bits LSB-first, PARITY drives the parity bit, STOP drives 1.
REQ-021 DATA SHALL use a 3-bit bit index; on bit_tick at index 7 the FSM goes to PARITY (PARITY_EN=1) or STOP (PARITY_EN=0), otherwise it shifts and increments the index.
REQ-022 On bit_tick, STOP SHALL go to IDLE; if empty=0 the next pop occurs in that IDLE cycle, so back-to-back frames are separated by exactly 1 idle clk.
REQ-023 tx SHALL be registered; the first START low appears 1 clk after the pop edge, and 2 clk after a write into an empty, idle FIFO.
REQ-024 A frame SHALL last exactly (10+PARITY_EN)*CLK_DIV clk.
REQ-025 wr_en and clr_err SHALL have no effect on the frame in progress.

Reset
REQ-026 On rst=0, and asynchronously, outputs SHALL take these values: tx=1, busy=0, full=0, empty=1, overrun_err=0; the FSM goes to IDLE; the FIFO pointers, count, baud counter and bit index go to 0.
REQ-027 Reset mid-frame SHALL abort the frame immediately; no partial frame resumes after release.
REQ-028 On the first edge after release, wr_en SHALL be honoured.

Structure
REQ-029 Package uart_pkg SHALL hold the FSM state enum, DATA_W=8 and the default CLK_DIV/DEPTH constants; these are shared with the receiver side.
REQ-030 The FIFO SHALL be a separate sub-module, tx_fifo, with ports push, pop, din, dout, full, empty and count; the FSM, baud counter and shift register live in uart_transmitter.

Verification
REQ-031 Case 1, CLK_DIV=16, PARITY_EN=1, one write of 0x55: tx low for 16 clk, then 1,0,1,0,1,0,1,0 (16 clk each), parity 0, stop 1; busy high for 176 clk.
REQ-032 Case 2, write 0x07, PARITY_EN=1: parity bit=1; with PARITY_EN=0 the frame is 160 clk and contains no parity slot.
REQ-033 Case 3, DEPTH=4, six writes on consecutive cycles while idle: the first is popped at once, writes 2-5 fill the FIFO (full=1), write 6 is dropped and sets overrun_err; clr_err then clears it; exactly 5 frames are sent, each 1 idle clk apart.
REQ-034 Case 4, full FIFO with a write coinciding with a STOP->IDLE pop: the write is accepted, overrun_err stays 0, and full stays 1.
REQ-035 Case 5, rst asserted at bit 4 of a frame: tx=1, busy=0 and empty=1 without waiting for a clk edge; after release, a write of 0xA3 produces a clean frame.
REQ-036 Case 6, loopback of tx into UartReceiver rx with matching baud, random bytes: every byte is received intact.
